// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multi-cycle MIPS control FSM
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_BRN    = 4'd10
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_SEXT   = 2'b10;
    localparam logic [1:0] SRCB_SEXT_2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multi-cycle MIPS datapath
//
// Sequences fetch/decode/execute/memory/writeback, drives aluop into the ALU
// control decoder, executes brn using that decoder's brnout, keeps the
// registered negative flag and a sticky illegal-opcode flag, and stalls on
// mem_ready for memory accesses.
// Ports: clk/reset (sync, active high); opcode, brnout, zero, alu_neg,
// mem_ready in; datapath strobes and selects, aluop1/aluop0, nflag,
// illegal_op and debug state out.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               brnout,
    input  logic               zero,
    input  logic               alu_neg,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic               aluop1,
    output logic               aluop0,
    output logic               nflag,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_e state_q, state_d;
    logic   nflag_q, nflag_d;
    logic   illegal_q, illegal_d;

    // zero is qualified by pcwritecond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            nflag_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            nflag_q   <= nflag_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        nflag_d     = nflag_q;
        illegal_d   = illegal_q;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_B;
        pcsource    = PCSRC_ALU;
        aluop1      = 1'b0;
        aluop0      = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                // IR and PC+4 are captured only in the cycle the read completes.
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_SEXT_2;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_SEXT;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
                state_d = brnout ? S_BRN : S_RWB;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                nflag_d  = alu_neg;
            end
            S_BEQ: begin
                alusrca     = 1'b1;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
            end
            S_BRN: begin
                // ALU passes rs + 0 straight to the PC when the last R-type was negative.
                alusrca = 1'b1;
                aluop1  = 1'b1;
                pcwrite = nflag_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign nflag      = nflag_q;
    assign illegal_op = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       brnout, zero, alu_neg, mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
    logic [1:0] alusrcb, pcsource;
    logic       nflag, illegal_op;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_control #(.STATE_W(4), .OP_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .brnout(brnout), .zero(zero),
        .alu_neg(alu_neg), .mem_ready(mem_ready), .pcwrite(pcwrite),
        .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg),
        .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsource(pcsource), .aluop1(aluop1),
        .aluop0(aluop0), .nflag(nflag), .illegal_op(illegal_op), .state(state)
    );

    // Control word order: pcwrite pcwritecond iord memread memwrite irwrite
    // memtoreg regdst regwrite alusrca alusrcb[1:0] pcsource[1:0] aluop1 aluop0
    localparam logic [15:0] C_FETCH_W = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
    localparam logic [15:0] C_FETCH_R = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
    localparam logic [15:0] C_DECODE  = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [15:0] C_MEMADR  = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [15:0] C_MEMRD   = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_MEMWB   = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [15:0] C_MEMWR   = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [15:0] C_EXEC    = 16'b0_0_0_0_0_0_0_0_0_1_00_00_10;
    localparam logic [15:0] C_RWB     = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [15:0] C_BEQ     = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [15:0] C_JUMP    = 16'b1_0_0_0_0_0_0_0_0_0_00_10_00;
    localparam logic [15:0] C_BRN0    = 16'b0_0_0_0_0_0_0_0_0_1_00_00_10;
    localparam logic [15:0] C_BRN1    = 16'b1_0_0_0_0_0_0_0_0_1_00_00_10;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, BAD = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        brn;
        logic        neg;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        nf;
        logic        ill;
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        nf;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t v(logic r, logic [5:0] o, logic b, logic n, logic rd,
                               logic [3:0] s, logic [15:0] c, logic nf, logic il);
        vec_t t;
        t = '{rst: r, op: o, brn: b, neg: n, rdy: rd, st: s, ctl: c, nf: nf, ill: il};
        return t;
    endfunction

    function automatic logic [15:0] dut_ctl();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, pcsource, aluop1, aluop0};
    endfunction

    task automatic check_out(input string name);
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (state !== e.st || dut_ctl() !== e.ctl || nflag !== e.nf || illegal_op !== e.ill) begin
            n_err++;
            $display("FAIL %s: got state=%0d ctl=%b nflag=%b ill=%b, want state=%0d ctl=%b nflag=%b ill=%b",
                     name, state, dut_ctl(), nflag, illegal_op, e.st, e.ctl, e.nf, e.ill);
        end
    endtask

    task automatic fill_table();
        // lw, no waits
        vecs.push_back(v(0, LW, 0, 0, 1, 0, C_FETCH_R, 0, 0));
        vecs.push_back(v(0, LW, 1, 0, 1, 1, C_DECODE,  0, 0));
        vecs.push_back(v(0, LW, 0, 0, 1, 2, C_MEMADR,  0, 0));
        vecs.push_back(v(0, LW, 0, 0, 1, 3, C_MEMRD,   0, 0));
        vecs.push_back(v(0, LW, 0, 1, 1, 4, C_MEMWB,   0, 0));
        // sw with three wait cycles in MEMWR
        vecs.push_back(v(0, SW, 0, 0, 1, 0, C_FETCH_R, 0, 0));
        vecs.push_back(v(0, SW, 0, 0, 1, 1, C_DECODE,  0, 0));
        vecs.push_back(v(0, SW, 0, 0, 1, 2, C_MEMADR,  0, 0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, SW, 0, 0, 0, 5, C_MEMWR, 0, 0));
        vecs.push_back(v(0, SW, 0, 0, 1, 5, C_MEMWR,   0, 0));
        // fetch wait, then R-type sub with negative result
        vecs.push_back(v(0, RT, 0, 0, 0, 0, C_FETCH_W, 0, 0));
        vecs.push_back(v(0, RT, 0, 0, 1, 0, C_FETCH_R, 0, 0));
        vecs.push_back(v(0, RT, 0, 0, 1, 1, C_DECODE,  0, 0));
        vecs.push_back(v(0, RT, 0, 0, 1, 6, C_EXEC,    0, 0));
        vecs.push_back(v(0, RT, 0, 1, 1, 7, C_RWB,     0, 0));
        // brn taken
        vecs.push_back(v(0, RT, 1, 0, 1, 0, C_FETCH_R, 1, 0));
        vecs.push_back(v(0, RT, 1, 0, 1, 1, C_DECODE,  1, 0));
        vecs.push_back(v(0, RT, 1, 0, 1, 6, C_EXEC,    1, 0));
        vecs.push_back(v(0, RT, 0, 0, 1, 10, C_BRN1,   1, 0));
        // beq, j: nflag must not follow alu_neg
        vecs.push_back(v(0, BQ, 0, 0, 1, 0, C_FETCH_R, 1, 0));
        vecs.push_back(v(0, BQ, 0, 0, 1, 1, C_DECODE,  1, 0));
        vecs.push_back(v(0, BQ, 0, 0, 1, 8, C_BEQ,     1, 0));
        vecs.push_back(v(0, JP, 0, 0, 1, 0, C_FETCH_R, 1, 0));
        vecs.push_back(v(0, JP, 0, 0, 1, 1, C_DECODE,  1, 0));
        vecs.push_back(v(0, JP, 0, 0, 1, 9, C_JUMP,    1, 0));
        // R-type positive result clears nflag
        vecs.push_back(v(0, RT, 0, 1, 1, 0, C_FETCH_R, 1, 0));
        vecs.push_back(v(0, RT, 0, 1, 1, 1, C_DECODE,  1, 0));
        vecs.push_back(v(0, RT, 0, 1, 1, 6, C_EXEC,    1, 0));
        vecs.push_back(v(0, RT, 0, 0, 1, 7, C_RWB,     1, 0));
        // brn not taken
        vecs.push_back(v(0, RT, 1, 1, 1, 0, C_FETCH_R, 0, 0));
        vecs.push_back(v(0, RT, 1, 1, 1, 1, C_DECODE,  0, 0));
        vecs.push_back(v(0, RT, 1, 1, 1, 6, C_EXEC,    0, 0));
        vecs.push_back(v(0, RT, 0, 1, 1, 10, C_BRN0,   0, 0));
        // illegal opcode, then lw still works
        vecs.push_back(v(0, BAD, 0, 0, 1, 0, C_FETCH_R, 0, 0));
        vecs.push_back(v(0, BAD, 0, 0, 1, 1, C_DECODE,  0, 0));
        vecs.push_back(v(0, LW, 0, 0, 1, 0, C_FETCH_R, 0, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 1, C_DECODE,  0, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 2, C_MEMADR,  0, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 3, C_MEMRD,   0, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 4, C_MEMWB,   0, 1));
        // R-type negative sets nflag, then reset during a stalled MEMRD
        vecs.push_back(v(0, RT, 0, 0, 1, 0, C_FETCH_R, 0, 1));
        vecs.push_back(v(0, RT, 0, 0, 1, 1, C_DECODE,  0, 1));
        vecs.push_back(v(0, RT, 0, 0, 1, 6, C_EXEC,    0, 1));
        vecs.push_back(v(0, RT, 0, 1, 1, 7, C_RWB,     0, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 0, C_FETCH_R, 1, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 1, C_DECODE,  1, 1));
        vecs.push_back(v(0, LW, 0, 0, 1, 2, C_MEMADR,  1, 1));
        vecs.push_back(v(0, LW, 0, 0, 0, 3, C_MEMRD,   1, 1));
        vecs.push_back(v(1, LW, 0, 0, 0, 3, C_MEMRD,   1, 1));
        vecs.push_back(v(0, LW, 0, 0, 0, 0, C_FETCH_W, 0, 0));
    endtask

    initial begin
        int cycles;
        int ir_pulses;
        reset = 1'b1; opcode = '0; brnout = 1'b0; zero = 1'b0; alu_neg = 1'b0; mem_ready = 1'b0;
        fill_table();
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op; brnout = vecs[i].brn;
            alu_neg = vecs[i].neg; mem_ready = vecs[i].rdy; zero = i[0];
            sb.push_back('{st: vecs[i].st, ctl: vecs[i].ctl, nf: vecs[i].nf, ill: vecs[i].ill});
            #1;
            check_out($sformatf("vec%0d", i));
        end

        // Hand-written: lw with random stalls in FETCH and MEMRD; count cycles and irwrite pulses.
        @(negedge clk);
        reset = 1'b0; opcode = LW; brnout = 1'b0; alu_neg = 1'b0;
        cycles = 0; ir_pulses = 0;
        begin : lw_walk
            int waits;
            waits = 0;
            do begin
                mem_ready = (($urandom & 3) != 0);
                if (!mem_ready && (state == 4'd0 || state == 4'd3)) waits++;
                #1;
                if (irwrite) ir_pulses++;
                cycles++;
                @(negedge clk);
            end while (state != 4'd0 && cycles < 50);
            n_vec++;
            if (cycles != 5 + waits) begin
                n_err++;
                $display("FAIL lw_cycles: got %0d cycles, want %0d", cycles, 5 + waits);
            end
            n_vec++;
            if (ir_pulses != 1) begin
                n_err++;
                $display("FAIL lw_irwrite: got %0d pulses, want 1", ir_pulses);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
